board_update_arbiter: RTL

- Owns the 8x8 board state (64 cells x 12 bits) that the VGA renderer reads on `board_data`.
- Arbitrates single-cell write requests from two requesters, the play/game logic (port A) and the cursor controller (port B), into a shadow copy.
- Copies the shadow copy into the displayed copy only at the start of vertical blanking, so the renderer never shows a half-updated frame.
- Sits between the game-logic/cursor modules and the display datapath.

---
 rtl/board_pkg.sv | 75 +++++++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/board_update_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared constants, cell layout, piece codes and helpers for the board
// update arbiter.
// Contents:
//   CELLS, CW, IDX_W  board geometry and cell width
//   cell bit positions (cursor colour/present, valid, side, type field)
//   piece_e           piece-type codes
//   merge_cell()      masked read-modify-write of one cell
//   START_BOARD       standard chess start position (used when INIT_BOARD_EN is defined)
package board_pkg;

   localparam int unsigned CELLS     = 64;
   localparam int unsigned CW        = 12;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned BOARD_W   = CELLS * CW;

   localparam int unsigned CUR_COLOR = 9;
   localparam int unsigned CUR_EN    = 8;
   localparam int unsigned VALID     = 4;
   localparam int unsigned SIDE      = 3;
   localparam int unsigned TYPE_LSB  = 0;
   localparam int unsigned TYPE_W    = 3;

   typedef enum logic [TYPE_W-1:0] {
      PieceNone   = 3'd0,
      PieceKing   = 3'd1,
      PieceQueen  = 3'd2,
      PieceBishop = 3'd3,
      PieceKnight = 3'd4,
      PieceRook   = 3'd5,
      PiecePawn   = 3'd6
   } piece_e;

   function automatic logic [CW-1:0] merge_cell(logic [CW-1:0] old_cell,
                                                logic [CW-1:0] mask,
                                                logic [CW-1:0] data);
      return (old_cell & ~mask) | (data & mask);
   endfunction

   function automatic logic [CW-1:0] make_piece(piece_e kind, logic side);
      logic [CW-1:0] c;
      c                     = '0;
      c[VALID]              = 1'b1;
      c[SIDE]               = side;
      c[TYPE_LSB +: TYPE_W] = kind;
      return c;
   endfunction

   function automatic piece_e back_rank(int unsigned col);
      piece_e p;
      case (col)
         0, 7:    p = PieceRook;
         1, 6:    p = PieceKnight;
         2, 5:    p = PieceBishop;
         3:       p = PieceQueen;
         default: p = PieceKing;
      endcase
      return p;
   endfunction

   // Black occupies rows 0-1 (side=1), white rows 6-7 (side=0).
   function automatic logic [BOARD_W-1:0] start_board();
      logic [BOARD_W-1:0] b;
      b = '0;
      for (int unsigned col = 0; col < 8; col++) begin
         b[(0 * 8 + col) * CW +: CW] = make_piece(back_rank(col), 1'b1);
         b[(1 * 8 + col) * CW +: CW] = make_piece(PiecePawn, 1'b1);
         b[(6 * 8 + col) * CW +: CW] = make_piece(PiecePawn, 1'b0);
         b[(7 * 8 + col) * CW +: CW] = make_piece(back_rank(col), 1'b0);
      end
      return b;
   endfunction

   localparam logic [BOARD_W-1:0] START_BOARD = start_board();

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with a combinational one-hot grant.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (pointer returns to requester 0)
//   en_i    grant enable; when low no grant is issued and the pointer holds
//   req_i   request vector, bit 0 = requester 0
//   gnt_o   one-hot grant, never set without the matching request
// The pointer only moves on a collision, so a lone requester never loses its priority.
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_ptr_q, rr_ptr_d;

   always_comb begin
      gnt_o    = 2'b00;
      rr_ptr_d = rr_ptr_q;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
               gnt_o    = rr_ptr_q ? 2'b10 : 2'b01;
               rr_ptr_d = ~rr_ptr_q;
            end
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/board_update_arbiter.sv
// board_update_arbiter: owns the 8x8 board shown by the renderer. Single-cell masked
// writes from port A (game logic) and port B (cursor) land in a shadow copy; the shadow
// is copied to the displayed copy only at vblank start, so a frame never tears.
// Ports:
//   pclk, rst            pixel clock; asynchronous active-high reset
//   ven                  vertical active-video enable
//   a_req/a_idx/a_mask/a_data, a_ack   port A write request and same-cycle grant
//   b_req/b_idx/b_mask/b_data, b_ack   port B, same as port A
//   board_data           displayed board, cell i at [i*12 +: 12]
//   dirty                shadow holds writes not yet displayed
//   commit_pulse         high for the cycle after a commit updated board_data
//   frame_cnt            wrapping count of vblank starts
// Build option: define INIT_BOARD_EN to reset both copies to the chess start position
// instead of all zeros.
module board_update_arbiter
   import board_pkg::*;
(
   input  logic                 pclk,
   input  logic                 rst,
   input  logic                 ven,
   input  logic                 a_req,
   input  logic [IDX_W-1:0]     a_idx,
   input  logic [CW-1:0]        a_mask,
   input  logic [CW-1:0]        a_data,
   output logic                 a_ack,
   input  logic                 b_req,
   input  logic [IDX_W-1:0]     b_idx,
   input  logic [CW-1:0]        b_mask,
   input  logic [CW-1:0]        b_data,
   output logic                 b_ack,
   output logic [BOARD_W-1:0]   board_data,
   output logic                 dirty,
   output logic                 commit_pulse,
   output logic [7:0]           frame_cnt
);

`ifdef INIT_BOARD_EN
   localparam logic [BOARD_W-1:0] RESET_BOARD = START_BOARD;
`else
   localparam logic [BOARD_W-1:0] RESET_BOARD = '0;
`endif

   logic [BOARD_W-1:0] shadow_q, shadow_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic               dirty_q, dirty_d;
   logic               commit_pulse_q, commit_pulse_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic               ven_q;

   logic               vbs;
   logic [1:0]         gnt;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [CW-1:0]      wr_mask, wr_data;

   assign vbs = ven_q & ~ven;

   // Acks are combinational, so gate with rst to keep them low while reset is held.
   rr_arbiter2 u_arb (
      .clk_i (pclk),
      .rst_i (rst),
      .en_i  (~vbs & ~rst),
      .req_i ({b_req, a_req}),
      .gnt_o (gnt)
   );

   assign a_ack   = gnt[0];
   assign b_ack   = gnt[1];
   assign wr_en   = |gnt;
   assign wr_idx  = gnt[1] ? b_idx  : a_idx;
   assign wr_mask = gnt[1] ? b_mask : a_mask;
   assign wr_data = gnt[1] ? b_data : a_data;

   // Grants are blocked during vbs, so a commit never races a shadow write.
   always_comb begin
      shadow_d       = shadow_q;
      board_d        = board_q;
      dirty_d        = dirty_q;
      commit_pulse_d = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      if (vbs) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
         if (dirty_q) begin
            board_d        = shadow_q;
            dirty_d        = 1'b0;
            commit_pulse_d = 1'b1;
         end
      end else if (wr_en) begin
         shadow_d[wr_idx * CW +: CW] = merge_cell(shadow_q[wr_idx * CW +: CW], wr_mask, wr_data);
         if (wr_mask != '0) begin
            dirty_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         shadow_q       <= RESET_BOARD;
         board_q        <= RESET_BOARD;
         dirty_q        <= 1'b0;
         commit_pulse_q <= 1'b0;
         frame_cnt_q    <= 8'd0;
         ven_q          <= 1'b0;
      end else begin
         shadow_q       <= shadow_d;
         board_q        <= board_d;
         dirty_q        <= dirty_d;
         commit_pulse_q <= commit_pulse_d;
         frame_cnt_q    <= frame_cnt_d;
         ven_q          <= ven;
      end
   end

   assign board_data   = board_q;
   assign dirty        = dirty_q;
   assign commit_pulse = commit_pulse_q;
   assign frame_cnt    = frame_cnt_q;

endmodule
